instr_fetch_unit: RTL and testbench

//  Upstream neighbour of the control FSM: owns PC and instruction register (IR).

---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, runs the two-cycle RAM fetch
// handshake and applies the control FSM's PC-update strobes.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nextInstruction,
  input  logic              PCinstruction,
  input  logic              PCEN,
  input  logic              BranchEN,
  input  logic              JmpEN,
  input  logic              JALEN,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_pc,
  output logic [3:0]        opCode1,
  output logic [3:0]        rdest,
  output logic [3:0]        conditionCode,
  output logic [3:0]        opCode2,
  output logic [3:0]        rsrc,
  output logic [3:0]        shiftAmtIn,
  output logic [7:0]        imm8,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              ir_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_CAPT,
    S_HOLD
  } state_e;

  state_e            state_q;
  logic [15:0]       ir_q;
  logic              ir_valid_q;
  logic              valid_sv_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [ADDR_W-1:0] ipc_sv_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] link_q, link_d;
  logic [ADDR_W-1:0] br_off;

  assign br_off = {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};

  // Strobes can overlap, so the first match wins.
  always_comb begin
    pc_d   = pc_q;
    link_d = link_q;
    if (PCEN) begin
      priority case (1'b1)
        JALEN: begin
          link_d = pc_q;
          pc_d   = jump_target;
        end
        JmpEN:         pc_d = jump_target;
        BranchEN:      pc_d = pc_q + br_off - ADDR_W'(1);
        PCinstruction: pc_d = pc_q + ADDR_W'(1);
        default:       pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      link_q <= '0;
    end else begin
      pc_q   <= pc_d;
      link_q <= link_d;
    end
  end

  // Fetch FSM; the pre-fetch IR status is kept so an abort can undo it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      valid_sv_q <= 1'b0;
      instr_pc_q <= '0;
      ipc_sv_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (nextInstruction) begin
            state_q    <= S_ADDR;
            valid_sv_q <= ir_valid_q;
            ipc_sv_q   <= instr_pc_q;
            instr_pc_q <= pc_q;
            ir_valid_q <= 1'b0;
          end
        end
        S_ADDR: begin
          if (nextInstruction) begin
            state_q    <= S_CAPT;
            ir_q       <= mem_rdata;
            ir_valid_q <= 1'b1;
          end else begin
            state_q    <= S_IDLE;
            ir_valid_q <= valid_sv_q;
            instr_pc_q <= ipc_sv_q;
          end
        end
        S_CAPT, S_HOLD: begin
          state_q <= nextInstruction ? S_HOLD : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr      = pc_q;
  assign pc            = pc_q;
  assign link_pc       = link_q;
  assign instr_pc      = instr_pc_q;
  assign ir_valid      = ir_valid_q;
  assign opCode1       = ir_q[15:12];
  assign rdest         = ir_q[11:8];
  assign conditionCode = ir_q[11:8];
  assign opCode2       = ir_q[7:4];
  assign rsrc          = ir_q[3:0];
  assign shiftAmtIn    = ir_q[3:0];
  assign imm8          = ir_q[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small RAM model and an
// expected-value queue.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        nextInstruction;
  logic        PCinstruction;
  logic        PCEN;
  logic        BranchEN;
  logic        JmpEN;
  logic        JALEN;
  logic [15:0] jump_target;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr;
  logic [15:0] pc;
  logic [15:0] link_pc;
  logic [3:0]  opCode1;
  logic [3:0]  rdest;
  logic [3:0]  conditionCode;
  logic [3:0]  opCode2;
  logic [3:0]  rsrc;
  logic [3:0]  shiftAmtIn;
  logic [7:0]  imm8;
  logic [15:0] instr_pc;
  logic        ir_valid;

  logic [15:0] ram [256];

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q [$];
  string       tag_q [$];

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk),
    .reset(reset),
    .nextInstruction(nextInstruction),
    .PCinstruction(PCinstruction),
    .PCEN(PCEN),
    .BranchEN(BranchEN),
    .JmpEN(JmpEN),
    .JALEN(JALEN),
    .jump_target(jump_target),
    .mem_rdata(mem_rdata),
    .mem_addr(mem_addr),
    .pc(pc),
    .link_pc(link_pc),
    .opCode1(opCode1),
    .rdest(rdest),
    .conditionCode(conditionCode),
    .opCode2(opCode2),
    .rsrc(rsrc),
    .shiftAmtIn(shiftAmtIn),
    .imm8(imm8),
    .instr_pc(instr_pc),
    .ir_valid(ir_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= ram[mem_addr[7:0]];

  task automatic exp_push(input string t, input logic [15:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [15:0] obs);
    string       t;
    logic [15:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic cyc(input logic nx, input logic pce, input logic pci,
                     input logic br, input logic jmp, input logic jal);
    nextInstruction = nx;
    PCEN            = pce;
    PCinstruction   = pci;
    BranchEN        = br;
    JmpEN           = jmp;
    JALEN           = jal;
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [15:0] t);
    jump_target = t;
    cyc(0, 1, 0, 0, 1, 0);
  endtask

  task automatic fetch();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    ram[0]     = 16'h5A37;
    ram[1]     = 16'hF123;
    ram[5]     = 16'h0080;
    ram[8'h10] = 16'h00FC;
    jump_target = '0;
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    exp_push("rst_pc", 16'h0000);      chk(pc);
    exp_push("rst_valid", 16'h0000);   chk({15'b0, ir_valid});
    exp_push("rst_link", 16'h0000);    chk(link_pc);
    exp_push("rst_op1", 16'h0000);     chk({12'b0, opCode1});

    // Fetch with PC increment in the first fetch cycle
    exp_push("t2_pc", 16'h0001);
    exp_push("t2_op1", 16'h0005);
    exp_push("t2_rdest", 16'h000A);
    exp_push("t2_cc", 16'h000A);
    exp_push("t2_op2", 16'h0003);
    exp_push("t2_rsrc", 16'h0007);
    exp_push("t2_shamt", 16'h0007);
    exp_push("t2_imm8", 16'h0037);
    exp_push("t2_ipc", 16'h0000);
    exp_push("t2_valid", 16'h0001);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk(pc);
    chk({12'b0, opCode1});
    chk({12'b0, rdest});
    chk({12'b0, conditionCode});
    chk({12'b0, opCode2});
    chk({12'b0, rsrc});
    chk({12'b0, shiftAmtIn});
    chk({8'b0, imm8});
    chk(instr_pc);
    chk({15'b0, ir_valid});

    // Reset in the middle of a fetch
    cyc(1, 0, 0, 0, 0, 0);
    exp_push("t6_start_valid", 16'h0000); chk({15'b0, ir_valid});
    reset = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    exp_push("t1_pc", 16'h0000);       chk(pc);
    exp_push("t1_op1", 16'h0000);      chk({12'b0, opCode1});
    exp_push("t1_valid", 16'h0000);    chk({15'b0, ir_valid});
    fetch();
    exp_push("t1_refetch", 16'h0005);  chk({12'b0, opCode1});

    // Branch, with and without PCEN
    jump_to(16'h0010);
    fetch();
    exp_push("t3_imm8", 16'h00FC);     chk({8'b0, imm8});
    exp_push("t3_ipc", 16'h0010);      chk(instr_pc);
    cyc(0, 0, 0, 1, 0, 0);
    exp_push("t3_nopcen", 16'h0010);   chk(pc);
    cyc(0, 1, 0, 1, 0, 0);
    exp_push("t3_branch", 16'h000B);   chk(pc);

    // Strobe priority
    jump_to(16'h0020);
    jump_target = 16'h0100;
    cyc(0, 1, 0, 0, 1, 1);
    exp_push("t4_link", 16'h0020);     chk(link_pc);
    exp_push("t4_pc", 16'h0100);       chk(pc);
    jump_target = 16'h0040;
    cyc(0, 1, 1, 1, 1, 0);
    exp_push("t4_jmp_prio", 16'h0040); chk(pc);
    exp_push("t4_link_hold", 16'h0020); chk(link_pc);

    // Wrap-around
    jump_to(16'hFFFF);
    cyc(0, 1, 1, 0, 0, 0);
    exp_push("t5_wrap", 16'h0000);     chk(pc);
    jump_to(16'h0005);
    fetch();
    cyc(0, 1, 1, 1, 0, 0);
    exp_push("t5_neg", 16'hFF84);      chk(pc);

    // Abort after one cycle, then a long hold
    jump_to(16'h0010);
    cyc(1, 0, 0, 0, 0, 0);
    exp_push("t6_mid_valid", 16'h0000); chk({15'b0, ir_valid});
    exp_push("t6_mid_ipc", 16'h0010);   chk(instr_pc);
    cyc(0, 0, 0, 0, 0, 0);
    exp_push("t6_ab_valid", 16'h0001);  chk({15'b0, ir_valid});
    exp_push("t6_ab_ipc", 16'h0005);    chk(instr_pc);
    exp_push("t6_ab_imm8", 16'h0080);   chk({8'b0, imm8});
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    ram[8'h10] = 16'hBEEF;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    exp_push("t6_hold_imm8", 16'h00FC); chk({8'b0, imm8});
    exp_push("t6_hold_op1", 16'h0000);  chk({12'b0, opCode1});
    exp_push("t6_hold_ipc", 16'h0010);  chk(instr_pc);
    exp_push("t6_hold_valid", 16'h0001); chk({15'b0, ir_valid});
    cyc(0, 1, 0, 0, 0, 0);
    exp_push("t6_after_imm8", 16'h00FC); chk({8'b0, imm8});
    exp_push("pcen_only_hold", 16'h0010); chk(pc);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_left observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
